// File: rtl/atm_pkg.sv
// ============================================================================
// Module   : atm_pkg
// Brief    : Shared ATM types and widths (dispenser state, amount/balance widths)
// Revision : 1.0
// ============================================================================
`default_nettype none

package atm_pkg;

    localparam int AMT_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        FEED      = 3'd2,
        WAIT_NOTE = 3'd3,
        DONE      = 3'd4,
        JAM       = 3'd5
    } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/atm_cycle_timer.sv
// ============================================================================
// Module   : atm_cycle_timer
// Brief    : Loadable up-counter with clear and terminal-count flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module atm_cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

`default_nettype wire

// File: rtl/atm_cash_dispenser.sv
// ============================================================================
// Module   : atm_cash_dispenser
// Brief    : Feeds approved notes one per motor burst, tracks cassette inventory
// Revision : 1.0
// ============================================================================
`default_nettype none

module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int CASSETTE_MAX = 200,
    parameter int FEED_CYCLES  = 4,
    parameter int JAM_TIMEOUT  = 16,
    parameter int LOW_THRESH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_req_i,
    input  logic [AMT_W-1:0] disp_amt_i,
    input  logic             note_sensor_i,
    input  logic             load_en_i,
    input  logic [CNT_W-1:0] load_count_i,
    input  logic             jam_clr_i,
    output logic             busy_o,
    output logic             motor_en_o,
    output logic             done_o,
    output logic             short_o,
    output logic             jam_o,
    output logic [AMT_W-1:0] dispensed_o,
    output logic [CNT_W-1:0] notes_left_o,
    output logic             low_cash_o
);

    localparam int TMR_MAX = (FEED_CYCLES > JAM_TIMEOUT) ? FEED_CYCLES : JAM_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    disp_state_t      state_q;
    logic             busy_q;
    logic             motor_q;
    logic             done_q;
    logic             short_q;
    logic             jam_q;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] dispensed_q;
    logic [CNT_W-1:0] notes_left_q;

    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_tmr_tc;
    logic [TMR_W-1:0] w_tc_val;
    logic [AMT_W-1:0] w_disp_inc;
    logic [CNT_W-1:0] w_load_clamped;

    // The timer is shared: feed-burst length in FEED, sensor timeout in WAIT_NOTE.
    // Terminal count JAM_TIMEOUT-2 means the jam decision lands as the timer reaches JAM_TIMEOUT-1.
    assign w_tmr_clr = (state_q == CHECK)
                     | ((state_q == FEED) && w_tmr_tc)
                     | ((state_q == WAIT_NOTE) && note_sensor_i);
    assign w_tmr_en  = (state_q == FEED) || (state_q == WAIT_NOTE);
    assign w_tc_val  = (state_q == FEED) ? TMR_W'(FEED_CYCLES - 1) : TMR_W'(JAM_TIMEOUT - 2);

    atm_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_tmr_clr),
        .en_i       (w_tmr_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_val_i   (w_tc_val),
        .tc_o       (w_tmr_tc)
    );

    assign w_disp_inc     = dispensed_q + AMT_W'(1);
    assign w_load_clamped = (load_count_i > CNT_W'(CASSETTE_MAX)) ? CNT_W'(CASSETTE_MAX)
                                                                  : load_count_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            motor_q      <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            jam_q        <= 1'b0;
            amt_q        <= '0;
            dispensed_q  <= '0;
            notes_left_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (disp_req_i) begin
                        amt_q       <= disp_amt_i;
                        dispensed_q <= '0;
                        short_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CHECK;
                    end else if (load_en_i) begin
                        notes_left_q <= w_load_clamped;
                    end
                end
                CHECK: begin
                    if (amt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (CNT_W'(amt_q) > notes_left_q) begin
                        done_q  <= 1'b1;
                        short_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        motor_q <= 1'b1;
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (w_tmr_tc) begin
                        motor_q <= 1'b0;
                        state_q <= WAIT_NOTE;
                    end
                end
                WAIT_NOTE: begin
                    if (note_sensor_i) begin
                        notes_left_q <= notes_left_q - CNT_W'(1);
                        dispensed_q  <= w_disp_inc;
                        if (w_disp_inc == amt_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            motor_q <= 1'b1;
                            state_q <= FEED;
                        end
                    end else if (w_tmr_tc) begin
                        jam_q   <= 1'b1;
                        state_q <= JAM;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                JAM: begin
                    if (jam_clr_i) begin
                        jam_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    motor_q <= 1'b0;
                    jam_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign motor_en_o   = motor_q;
    assign done_o       = done_q;
    assign short_o      = short_q;
    assign jam_o        = jam_q;
    assign dispensed_o  = dispensed_q;
    assign notes_left_o = notes_left_q;
    assign low_cash_o   = (notes_left_q < CNT_W'(LOW_THRESH));

endmodule

`default_nettype wire

// File: tb/tb_atm_cash_dispenser.sv
// ============================================================================
// Module   : tb_atm_cash_dispenser
// Brief    : Directed self-checking bench for atm_cash_dispenser
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atm_cash_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_req;
    logic [2:0] disp_amt;
    logic       note_sensor;
    logic       load_en;
    logic [7:0] load_count;
    logic       jam_clr;
    logic       busy, motor_en, done, short_o, jam, low_cash;
    logic [2:0] dispensed;
    logic [7:0] notes_left;

    int tests = 0;
    int fails = 0;
    int motor_cycles = 0;
    int done_pulses = 0;
    int blen;

    always #5 clk = ~clk;

    atm_cash_dispenser dut (
        .clk           (clk),
        .rst           (rst),
        .disp_req_i    (disp_req),
        .disp_amt_i    (disp_amt),
        .note_sensor_i (note_sensor),
        .load_en_i     (load_en),
        .load_count_i  (load_count),
        .jam_clr_i     (jam_clr),
        .busy_o        (busy),
        .motor_en_o    (motor_en),
        .done_o        (done),
        .short_o       (short_o),
        .jam_o         (jam),
        .dispensed_o   (dispensed),
        .notes_left_o  (notes_left),
        .low_cash_o    (low_cash)
    );

    always @(posedge clk) begin
        if (motor_en === 1'b1) motor_cycles++;
        if (done === 1'b1) done_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for a motor burst and measures it; returns in the first cycle after it ends.
    task automatic feed_burst(output int len);
        int guard = 0;
        while (motor_en !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        len = 0;
        while (motor_en === 1'b1 && len < 40) begin
            step();
            len++;
        end
    endtask

    task automatic load(input logic [7:0] v);
        load_en = 1'b1; load_count = v;
        step();
        load_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; disp_req = 0; disp_amt = 0; note_sensor = 0;
        load_en = 0; load_count = 0; jam_clr = 0;

        // 1. reset
        step(); step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_motor", int'(motor_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short_o), 0);
        chk("rst_jam", int'(jam), 0);
        chk("rst_dispensed", int'(dispensed), 0);
        chk("rst_notes", int'(notes_left), 0);
        chk("rst_low", int'(low_cash), 1);

        // 2. normal three-note withdrawal
        load(8'd50);
        chk("t2_load", int'(notes_left), 50);
        chk("t2_low", int'(low_cash), 0);
        motor_cycles = 0; done_pulses = 0;
        disp_req = 1'b1; disp_amt = 3'd3;
        step();
        disp_req = 1'b0;
        chk("t2_busy", int'(busy), 1);
        for (int n = 0; n < 3; n++) begin
            feed_burst(blen);
            chk("t2_burst_len", blen, 4);
            step();
            note_sensor = 1'b1;
            step();
            note_sensor = 1'b0;
        end
        chk("t2_done", int'(done), 1);
        chk("t2_short", int'(short_o), 0);
        chk("t2_dispensed", int'(dispensed), 3);
        chk("t2_notes", int'(notes_left), 47);
        step();
        chk("t2_idle_busy", int'(busy), 0);
        chk("t2_done_once", done_pulses, 1);
        chk("t2_motor_total", motor_cycles, 12);

        // 3. shortfall
        load(8'd2);
        motor_cycles = 0; done_pulses = 0;
        disp_req = 1'b1; disp_amt = 3'd5;
        step();
        disp_req = 1'b0;
        chk("t3_check_done", int'(done), 0);
        step();
        chk("t3_done", int'(done), 1);
        chk("t3_short", int'(short_o), 1);
        step();
        chk("t3_short_hold", int'(short_o), 1);
        chk("t3_motor", motor_cycles, 0);
        chk("t3_notes", int'(notes_left), 2);
        chk("t3_low", int'(low_cash), 1);

        // 4. jam on second note
        load(8'd20);
        done_pulses = 0;
        disp_req = 1'b1; disp_amt = 3'd2;
        step();
        disp_req = 1'b0;
        chk("t4_short_cleared", int'(short_o), 0);
        feed_burst(blen);
        note_sensor = 1'b1;
        step();
        note_sensor = 1'b0;
        feed_burst(blen);
        chk("t4_burst2_len", blen, 4);
        for (int i = 0; i < 14; i++) step();
        chk("t4_no_jam_early", int'(jam), 0);
        step();
        chk("t4_jam", int'(jam), 1);
        chk("t4_dispensed", int'(dispensed), 1);
        chk("t4_notes", int'(notes_left), 19);
        chk("t4_jam_busy", int'(busy), 1);
        chk("t4_jam_motor", int'(motor_en), 0);
        disp_req = 1'b1; load_en = 1'b1; load_count = 8'd99; note_sensor = 1'b1;
        step();
        disp_req = 1'b0; load_en = 1'b0; note_sensor = 1'b0;
        chk("t4_jam_ignores", int'(notes_left), 19);
        chk("t4_jam_hold", int'(jam), 1);
        jam_clr = 1'b1;
        step();
        jam_clr = 1'b0;
        chk("t4_clr_jam", int'(jam), 0);
        chk("t4_clr_busy", int'(busy), 0);
        chk("t4_no_done", done_pulses, 0);

        // 5. clamp, load/req collision, zero amount
        load(8'd250);
        chk("t5_clamp", int'(notes_left), 200);
        motor_cycles = 0;
        load_en = 1'b1; load_count = 8'd5; disp_req = 1'b1; disp_amt = 3'd0;
        step();
        load_en = 1'b0; disp_req = 1'b0;
        chk("t5_load_dropped", int'(notes_left), 200);
        step();
        chk("t5_done", int'(done), 1);
        chk("t5_short", int'(short_o), 0);
        step();
        chk("t5_motor", motor_cycles, 0);

        // 6. reset mid-FEED, then latency of a single note
        done_pulses = 0;
        disp_req = 1'b1; disp_amt = 3'd3;
        step();
        disp_req = 1'b0;
        step(); step();
        chk("t6_in_feed", int'(motor_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_motor", int'(motor_en), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_notes", int'(notes_left), 0);
        step(); step();
        chk("t6_no_done", done_pulses, 0);
        load(8'd50);
        disp_req = 1'b1; disp_amt = 3'd1;
        step();
        disp_req = 1'b0;
        chk("t6_c1_motor", int'(motor_en), 0);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("t6_motor_on", int'(motor_en), 1);
        end
        step();
        chk("t6_c6_motor", int'(motor_en), 0);
        note_sensor = 1'b1;
        step();
        note_sensor = 1'b0;
        chk("t6_c7_done", int'(done), 1);
        chk("t6_notes", int'(notes_left), 49);
        chk("t6_dispensed", int'(dispensed), 1);
        step();
        chk("t6_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
